soft_rst_ctrl_mc: RTL
=====================

# soft_rst_ctrl_mc

Parametrised soft-reset sequencer for an N-channel datapath. On a software request it halts DMA, waits for every unmasked channel to report quiet (with a bounded timeout), and holds a synchronous soft reset for a programmable width. It also drives the host-side asynchronous reset, then acknowledges with a four-phase handshake. It sits between the register block and the DMA/TX/RX channel logic.

## Interface
Parameters:
- NUM_CH, 2, number of quiet-status channels (>=1)
- RST_CYCLES, 16, soft-reset assertion width in clk cycles (>=1)
- HALT_TIMEOUT, 1024, max cycles spent in HALT; 0 disables the timeout
- SYNC_STAGES, 2, synchroniser depth for ch_quiet and for hs_async_rst_n release (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_soft_rst  in  1  soft-reset request, level, four-phase
- soft_rst_dne  out  1  done acknowledge, high in DONE
- soft_rst_busy  out  1  high whenever state != IDLE
- timeout_err  out  1  last sequence entered RST via timeout
- dma_halt  out  1  halt DMA activity
- ch_quiet  in  NUM_CH  per-channel dormant flag, asynchronous to clk
- ch_mask  in  NUM_CH  1 = ignore channel in quiet check (quasi-static)
- soft_rst  out  1  synchronous soft reset to datapath
- hs_async_rst_n  out  1  active-low reset to host side

## Operation
- All outputs are registered. Reset values: dma_halt=0, soft_rst=0, soft_rst_dne=0, soft_rst_busy=0, timeout_err=0, hs_async_rst_n=0, state=IDLE, counter=0, quiet synchronisers=0.
- ch_quiet passes through a SYNC_STAGES-flop synchroniser. all_quiet = &(ch_quiet_sync | ch_mask).
- Single counter, width $clog2(max(RST_CYCLES, HALT_TIMEOUT, SYNC_STAGES)+1). Cleared on every state transition.
- States:
  - IDLE: outputs inactive. req_soft_rst=1 -> HALT; clear timeout_err on this transition.
  - HALT: dma_halt=1; counter increments.
    - all_quiet=1 -> RST.
    - Else if HALT_TIMEOUT!=0 and counter==HALT_TIMEOUT-1 -> RST and set timeout_err=1.
  - RST: dma_halt=1, soft_rst=1, hs_async_rst_n=0. Stay exactly RST_CYCLES cycles -> REL.
  - REL: dma_halt=1, soft_rst=0, hs_async_rst_n=1. Stay exactly SYNC_STAGES cycles -> DONE.
  - DONE: dma_halt=0, soft_rst_dne=1. req_soft_rst=0 -> IDLE, and soft_rst_dne drops.
- Once out of IDLE, the sequence always completes. Dropping req_soft_rst mid-sequence does not abort it. DONE is then held one cycle only.
- timeout_err is sticky until the next IDLE->HALT transition.
- Power-on release: hs_async_rst_n asserts asynchronously with rst_n. It deasserts SYNC_STAGES rising edges after rst_n deasserts, via a shift chain of 1s; it is not released combinationally.
- all_quiet is sampled only in HALT. Quiet dropping during RST/REL is ignored.
- ch_mask all ones: HALT exits after 1 cycle.

## Timing
- Request sampled high at edge n: dma_halt and busy are high after edge n.
- HALT lasts at least 1 cycle. With HALT_TIMEOUT!=0 it lasts at most HALT_TIMEOUT cycles.
- soft_rst is high for exactly RST_CYCLES cycles. hs_async_rst_n is low for the same cycles.
- soft_rst_dne rises SYNC_STAGES cycles after soft_rst falls.
- dma_halt falls on the same edge soft_rst_dne rises.
- soft_rst_dne falls on the edge after req_soft_rst is sampled low.
- A new request can be accepted on the cycle after return to IDLE (IDLE is at least 1 cycle).
- Minimum request-to-done latency, with quiet already synchronised: 1 + 1 + RST_CYCLES + SYNC_STAGES edges.
- rst_n assertion at any state: all outputs go to reset values immediately (asynchronous). The sequence is lost and no done is issued.

## Test plan
Bench config: NUM_CH=3, RST_CYCLES=4, HALT_TIMEOUT=8, SYNC_STAGES=2.

- Power-on: rst_n low for 3 cycles, then high -> all outputs 0, hs_async_rst_n rises exactly 2 edges after release, busy stays 0.
- Nominal: ch_quiet=3'b111, ch_mask=0, pulse req high until dne -> dma_halt high 1 cycle after req, HALT 1 cycle, soft_rst high 4 cycles with hs_async_rst_n low, dne 2 cycles later, timeout_err=0. Drop req -> dne low next cycle, busy low.
- Masking: ch_quiet=3'b011, ch_mask=3'b100 -> completes as nominal. ch_mask=0 with same quiet -> timeout path.
- Timeout: ch_quiet=0 -> HALT exactly 8 cycles, soft_rst 4 cycles, dne asserted with timeout_err=1. Next request clears timeout_err on HALT entry.
- Early req drop: req high 1 cycle, ch_quiet raised after 5 cycles -> full sequence runs, DONE lasts 1 cycle, back to IDLE.
- Reset mid-RST: assert rst_n during the 2nd soft_rst cycle -> soft_rst=0, dma_halt=0, hs_async_rst_n=0 immediately. After release, no dne, state IDLE.

Source files
------------

// File: rtl/soft_rst_ctrl_mc_if.sv
// ---------------------------------------------------------------------------
// soft_rst_ctrl_mc_if : soft-reset request/ack, channel status and reset outputs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface soft_rst_ctrl_mc_if #(
  parameter int NUM_CH = 2
);
  logic              req_soft_rst;
  logic              soft_rst_dne;
  logic              soft_rst_busy;
  logic              timeout_err;
  logic              dma_halt;
  logic [NUM_CH-1:0] ch_quiet;
  logic [NUM_CH-1:0] ch_mask;
  logic              soft_rst;
  logic              hs_async_rst_n;

  modport master (
    output req_soft_rst, ch_quiet, ch_mask,
    input  soft_rst_dne, soft_rst_busy, timeout_err, dma_halt, soft_rst, hs_async_rst_n
  );

  modport slave (
    input  req_soft_rst, ch_quiet, ch_mask,
    output soft_rst_dne, soft_rst_busy, timeout_err, dma_halt, soft_rst, hs_async_rst_n
  );
endinterface

`default_nettype wire

// File: rtl/soft_rst_ctrl_mc.sv
// ---------------------------------------------------------------------------
// soft_rst_ctrl_mc : halt / quiesce / reset / release sequencer with 4-phase ack
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module soft_rst_ctrl_mc #(
  parameter int NUM_CH       = 2,
  parameter int RST_CYCLES   = 16,
  parameter int HALT_TIMEOUT = 1024,
  parameter int SYNC_STAGES  = 2
) (
  input logic               clk,
  input logic               rst_n,
  soft_rst_ctrl_mc_if.slave bus
);

  localparam int MAX_A   = (RST_CYCLES > HALT_TIMEOUT) ? RST_CYCLES : HALT_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > SYNC_STAGES) ? MAX_A : SYNC_STAGES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HALT_LAST = CW'(HALT_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(SYNC_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_RST  = 3'd2,
    S_REL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-2:0] pwr_q, pwr_d;
  logic dma_halt_q, dma_halt_d;
  logic soft_rst_q, soft_rst_d;
  logic dne_q, dne_d;
  logic busy_q, busy_d;
  logic terr_q, terr_d;
  logic hs_q, hs_d;
  logic all_quiet;

  // pwr chain plus hs_q form the SYNC_STAGES-deep release path for hs_async_rst_n
  always_comb begin
    sync_d[0] = bus.ch_quiet;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    pwr_d[0] = 1'b1;
    for (int i = 1; i < SYNC_STAGES - 1; i++) begin
      pwr_d[i] = pwr_q[i-1];
    end
  end

  assign all_quiet = &(sync_q[SYNC_STAGES-1] | bus.ch_mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_soft_rst) begin
          state_d = S_HALT;
          terr_d  = 1'b0;
        end
      end
      S_HALT: begin
        if (all_quiet) begin
          state_d = S_RST;
        end else if ((HALT_TIMEOUT != 0) && (cnt_q == HALT_LAST)) begin
          state_d = S_RST;
          terr_d  = 1'b1;
        end
      end
      S_RST:  if (cnt_q == RST_LAST) state_d = S_REL;
      S_REL:  if (cnt_q == REL_LAST) state_d = S_DONE;
      S_DONE: begin
        cnt_d = '0;
        if (!bus.req_soft_rst) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they change on the transition edge
    dma_halt_d = (state_d == S_HALT) || (state_d == S_RST) || (state_d == S_REL);
    soft_rst_d = (state_d == S_RST);
    dne_d      = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    hs_d       = pwr_q[SYNC_STAGES-2] && (state_d != S_RST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pwr_q      <= '0;
      dma_halt_q <= 1'b0;
      soft_rst_q <= 1'b0;
      dne_q      <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      hs_q       <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwr_q      <= pwr_d;
      dma_halt_q <= dma_halt_d;
      soft_rst_q <= soft_rst_d;
      dne_q      <= dne_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      hs_q       <= hs_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign bus.dma_halt       = dma_halt_q;
  assign bus.soft_rst       = soft_rst_q;
  assign bus.soft_rst_dne   = dne_q;
  assign bus.soft_rst_busy  = busy_q;
  assign bus.timeout_err    = terr_q;
  assign bus.hs_async_rst_n = hs_q;

endmodule

`default_nettype wire
